instr_queue_mp: RTL and testbench
=================================

// Module: instr_queue_mp
// PURPOSE
//  Parametrised multi-port instruction queue between fetch and decode/issue.
//  Accepts up to WR_PORTS fetched instructions per cycle. Presents up to RD_PORTS
//  in-order lanes to issue, each tagged as delay slot or not.
//  Flushes on redirect. Can preserve the branch delay slot across a flush,
//  including when that slot has not yet arrived from fetch.
// PARAMETERS
//  DEPTH     16  entries; power of 2, >= 2*max(WR_PORTS,RD_PORTS)
//  WR_PORTS  2   fetch lanes per cycle (1..4)
//  RD_PORTS  2   issue lanes per cycle (1..4)
//  DATA_W    32  instruction word width
//  ADDR_W    32  PC width
//  EXP_W     12  fetch-exception code width
// PORTS
//  clk           in   1                    clock, all state on posedge
//  rst_n         in   1                    async active-low reset
//  flush         in   1                    drop all entries and any delay-slot state
//  flush_keep_ds in   1                    drop all entries but keep the next unconsumed one as delay slot
//  wr_cnt        in   $clog2(WR_PORTS+1)   lanes 0..wr_cnt-1 valid this cycle
//  wr_data       in   WR_PORTS*DATA_W      instruction words, lane 0 oldest
//  wr_addr       in   WR_PORTS*ADDR_W      PCs
//  wr_exp        in   WR_PORTS*EXP_W       exception code per lane
//  wr_ready      out  1                    free slots >= WR_PORTS
//  rd_valid      out  RD_PORTS             thermometer code, lane 0 first
//  rd_data       out  RD_PORTS*DATA_W      issue-lane instruction words
//  rd_addr       out  RD_PORTS*ADDR_W      issue-lane PCs
//  rd_exp        out  RD_PORTS*EXP_W       issue-lane exception codes
//  rd_is_ds      out  RD_PORTS             lane holds a delay-slot instruction
//  rd_branch     in   RD_PORTS             decoder: lane i is a branch/jump (comb.)
//  rd_cnt        in   $clog2(RD_PORTS+1)   lanes consumed this cycle; must be <= popcount(rd_valid)
//  count         out  $clog2(DEPTH+1)      occupied entries
//  perf_issued   out  64                   total instructions consumed
// BEHAVIOUR
//  Reset (async)
//   - wr_ptr, rd_ptr, count, perf_issued, ds_pend = 0; state = NORMAL.
//   - Outputs at reset: rd_valid = 0, rd_is_ds = 0, wr_ready = 1, count = 0.
//   - rd_data/rd_addr/rd_exp are 0 whenever their rd_valid bit is 0.
//  Writes
//   - Lanes 0..wr_cnt-1 go to wr_ptr..wr_ptr+wr_cnt-1, mod DEPTH.
//   - Write latency: visible on rd_* the cycle after the write (no bypass).
//   - wr_cnt > free slots is a protocol error. Assert it in simulation; RTL drops the whole write.
//  Reads
//   - Lane i valid iff i < count; it shows entry rd_ptr+i.
//   - Consumption is a prefix: rd_ptr += rd_cnt.
//   - count_next = count + wr_cnt - rd_cnt. Simultaneous read and write are legal at full and at empty.
//   - Pointers are log2(DEPTH) bits and wrap naturally.
//  Delay-slot tagging
//   - rd_is_ds[0] = ds_pend.
//   - rd_is_ds[i>0] = rd_branch[i-1] & rd_valid[i].
//   - On consume, ds_pend <= rd_branch[rd_cnt-1]. ds_pend is unchanged if rd_cnt = 0.
//  States
//   - NORMAL: operation as above.
//   - DS_HOLD: lane 0 shows ds_reg with rd_is_ds[0] = 1; other lanes invalid.
//     rd_cnt >= 1 -> NORMAL, ds_pend <= 0.
//     Writes enqueue normally meanwhile; queue is empty on entry.
//   - DS_WAIT: rd_valid = 0.
//     Write with wr_cnt >= 1 -> lane 0 captured into ds_reg, lanes 1.. dropped, -> DS_HOLD.
//  Flush (priority flush > flush_keep_ds > normal)
//   - flush: wr_ptr = rd_ptr = count = 0, ds_pend = 0, -> NORMAL. This cycle's writes and reads are discarded.
//   - flush_keep_ds: candidate = entry rd_ptr+rd_cnt (the first entry not consumed this cycle).
//     Candidate exists in queue -> ds_reg <= it, -> DS_HOLD.
//     Else wr_cnt >= 1 -> ds_reg <= write lane 0, -> DS_HOLD.
//     Else -> DS_WAIT.
//     Pointers and count are cleared in all three cases; all other writes in this cycle are dropped.
//     Reads in the flush cycle still count toward perf_issued.
//   - flush_keep_ds while in DS_HOLD or DS_WAIT keeps the current state and ds_reg.
//  perf_issued
//   - += rd_cnt in NORMAL; += 1 on DS_HOLD consume.
//   - Saturates at 2^64-1.
// STRUCTURE
//  - Shared package cpu_defs_pkg: typedef inst_entry_t {data, addr, exp};
//    enum iq_state_e {IQ_NORMAL, IQ_DS_HOLD, IQ_DS_WAIT}.
//  - Sub-module instr_queue_ram: DEPTH x inst_entry_t storage with WR_PORTS write ports
//    and RD_PORTS async read ports at base+i.
//  - Top level holds pointers, count, FSM, ds_reg, tagging and perf counter.
// TESTING
//  1. Write 2/cycle for 8 cycles, no reads -> count = 16, wr_ready = 0 from cycle 7.
//     Then read 2/cycle -> PCs out in order, count = 0 after 8 cycles.
//  2. Full queue, wr_cnt = 2 with rd_cnt = 2 in one cycle -> count stays 16, data order intact across wrap.
//  3. Queue holds PCs 0x100..0x10C, rd_branch[0] = 1, rd_cnt = 1, flush_keep_ds.
//     -> Next cycle lane 0 = 0x104, rd_is_ds[0] = 1, count = 0; consume -> NORMAL.
//  4. Queue empty, flush_keep_ds with wr_cnt = 0 -> DS_WAIT, rd_valid = 0.
//     Write 0x200/0x204 -> lane 0 = 0x200 tagged DS; 0x204 dropped.
//  5. flush and flush_keep_ds together while count = 5 -> count = 0, NORMAL, rd_is_ds = 0.
//  6. Lane 1 branch, rd_cnt = 2 -> next cycle rd_is_ds[0] = 1.
//     Assert rst_n low mid-operation -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared front-end types for fetch/decode/issue
package cpu_defs_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 32;
  localparam int CPU_EXP_W  = 12;

  typedef struct packed {
    logic [CPU_DATA_W-1:0] data;
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_EXP_W-1:0]  exp;
  } inst_entry_t;

  typedef enum logic [1:0] {
    IQ_NORMAL  = 2'd0,
    IQ_DS_HOLD = 2'd1,
    IQ_DS_WAIT = 2'd2
  } iq_state_e;

endpackage

// File: rtl/instr_queue_ram.sv
// rtl/instr_queue_ram.sv - instruction queue storage, multi-port write, async read at base+i
module instr_queue_ram
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 3,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = $bits(inst_entry_t)
) (
  input  logic                        clk,
  input  logic [WR_PORTS-1:0]         wr_en,
  input  logic [WR_PORTS*PTR_W-1:0]   wr_idx,
  input  logic [WR_PORTS*ENTRY_W-1:0] wr_entry,
  input  logic [PTR_W-1:0]            rd_base,
  output logic [RD_PORTS*ENTRY_W-1:0] rd_entry
);

  inst_entry_t mem [DEPTH];

  // Write lanes always target distinct slots, so per-lane ordering is irrelevant.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (wr_en[i]) begin
        mem[wr_idx[i*PTR_W +: PTR_W]] <= wr_entry[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

  always_comb begin
    rd_entry = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_entry[i*ENTRY_W +: ENTRY_W] = mem[rd_base + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/instr_queue_mp.sv
// rtl/instr_queue_mp.sv - multi-port fetch-to-issue instruction queue with delay-slot preservation
module instr_queue_mp
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2,
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int EXP_W    = CPU_EXP_W,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int WC_W    = $clog2(WR_PORTS + 1),
  localparam int RC_W    = $clog2(RD_PORTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       flush_keep_ds,
  input  logic [WC_W-1:0]            wr_cnt,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data,
  input  logic [WR_PORTS*ADDR_W-1:0] wr_addr,
  input  logic [WR_PORTS*EXP_W-1:0]  wr_exp,
  output logic                       wr_ready,
  output logic [RD_PORTS-1:0]        rd_valid,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*EXP_W-1:0]  rd_exp,
  output logic [RD_PORTS-1:0]        rd_is_ds,
  input  logic [RD_PORTS-1:0]        rd_branch,
  input  logic [RC_W-1:0]            rd_cnt,
  output logic [CNT_W-1:0]           count,
  output logic [63:0]                perf_issued
);

  localparam int ENTRY_W = $bits(inst_entry_t);
  localparam logic [1:0] S_NORMAL = IQ_NORMAL;
  localparam logic [1:0] S_HOLD   = IQ_DS_HOLD;
  localparam logic [1:0] S_WAIT   = IQ_DS_WAIT;

  logic [1:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             ds_pend;
  inst_entry_t      ds_reg;

  inst_entry_t                        wr_lane [WR_PORTS];
  inst_entry_t                        rd_lane [RD_PORTS+1];
  logic [WR_PORTS*ENTRY_W-1:0]        wr_flat;
  logic [WR_PORTS*PTR_W-1:0]          wr_idx;
  logic [WR_PORTS-1:0]                ram_we;
  logic [(RD_PORTS+1)*ENTRY_W-1:0]    ram_rd;

  logic [CNT_W:0]   free;
  logic             wr_ok;
  logic [WC_W-1:0]  n_wr;
  logic             wr_en_all;
  logic             br_last;
  inst_entry_t      cand;
  logic             has_cand;
  logic [RC_W-1:0]  perf_inc;
  logic [64:0]      perf_sum;
  logic [63:0]      perf_next;

  // Entries consumed this cycle free their slots, so a full queue can accept while draining.
  always_comb begin
    free = (CNT_W+1)'(DEPTH) - {1'b0, count};
    if (state == S_NORMAL) begin
      free = free + (CNT_W+1)'(rd_cnt);
    end
    wr_ok     = ((CNT_W+1)'(wr_cnt) <= free) && (wr_cnt <= WC_W'(WR_PORTS));
    n_wr      = wr_ok ? wr_cnt : '0;
    wr_en_all = !flush && !flush_keep_ds && wr_ok && (state != S_WAIT);
  end

  always_comb begin
    wr_flat = '0;
    wr_idx  = '0;
    ram_we  = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      wr_lane[i].data = wr_data[i*DATA_W +: DATA_W];
      wr_lane[i].addr = wr_addr[i*ADDR_W +: ADDR_W];
      wr_lane[i].exp  = wr_exp[i*EXP_W +: EXP_W];
      wr_flat[i*ENTRY_W +: ENTRY_W] = wr_lane[i];
      wr_idx[i*PTR_W +: PTR_W]      = wr_ptr + PTR_W'(i);
      ram_we[i] = wr_en_all && (WC_W'(i) < wr_cnt);
    end
  end

  // One extra read port exposes the first entry beyond the consumed prefix.
  instr_queue_ram #(
    .DEPTH    (DEPTH),
    .WR_PORTS (WR_PORTS),
    .RD_PORTS (RD_PORTS + 1)
  ) u_ram (
    .clk      (clk),
    .wr_en    (ram_we),
    .wr_idx   (wr_idx),
    .wr_entry (wr_flat),
    .rd_base  (rd_ptr),
    .rd_entry (ram_rd)
  );

  always_comb begin
    for (int i = 0; i <= RD_PORTS; i++) begin
      rd_lane[i] = ram_rd[i*ENTRY_W +: ENTRY_W];
    end
    cand    = rd_lane[0];
    br_last = 1'b0;
    for (int i = 0; i <= RD_PORTS; i++) begin
      if (rd_cnt == RC_W'(i)) cand = rd_lane[i];
    end
    for (int i = 0; i < RD_PORTS; i++) begin
      if (rd_cnt == RC_W'(i + 1)) br_last = rd_branch[i];
    end
    has_cand = CNT_W'(rd_cnt) < count;
  end

  always_comb begin
    perf_inc = '0;
    if (!flush) begin
      if (state == S_NORMAL) begin
        perf_inc = rd_cnt;
      end else if (state == S_HOLD && !flush_keep_ds && rd_cnt != '0) begin
        perf_inc = RC_W'(1);
      end
    end
    perf_sum  = {1'b0, perf_issued} + 65'(perf_inc);
    perf_next = perf_sum[64] ? '1 : perf_sum[63:0];
  end

  always_comb begin
    inst_entry_t sel;
    rd_valid = '0;
    rd_is_ds = '0;
    rd_data  = '0;
    rd_addr  = '0;
    rd_exp   = '0;
    sel      = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      if (state == S_NORMAL) begin
        rd_valid[i] = CNT_W'(i) < count;
        sel         = rd_lane[i];
      end else if (state == S_HOLD) begin
        rd_valid[i] = (i == 0);
        sel         = ds_reg;
      end
      if (rd_valid[i]) begin
        rd_data[i*DATA_W +: DATA_W] = sel.data;
        rd_addr[i*ADDR_W +: ADDR_W] = sel.addr;
        rd_exp[i*EXP_W +: EXP_W]    = sel.exp;
      end
    end
    rd_is_ds[0] = (state == S_HOLD) || (state == S_NORMAL && ds_pend);
    for (int i = 1; i < RD_PORTS; i++) begin
      rd_is_ds[i] = rd_branch[i-1] && rd_valid[i];
    end
  end

  assign wr_ready = ((CNT_W+1)'(DEPTH) - {1'b0, count}) >= (CNT_W+1)'(WR_PORTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_NORMAL;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ds_pend     <= 1'b0;
      ds_reg      <= '0;
      perf_issued <= '0;
    end else begin
      perf_issued <= perf_next;
      if (flush) begin
        state   <= S_NORMAL;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        ds_pend <= 1'b0;
      end else if (flush_keep_ds) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        // An already-pending delay slot survives a second redirect untouched.
        if (state == S_NORMAL) begin
          ds_pend <= 1'b0;
          if (has_cand) begin
            ds_reg <= cand;
            state  <= S_HOLD;
          end else if (wr_cnt != '0) begin
            ds_reg <= wr_lane[0];
            state  <= S_HOLD;
          end else begin
            state <= S_WAIT;
          end
        end
      end else begin
        case (state)
          S_NORMAL: begin
            wr_ptr <= wr_ptr + PTR_W'(n_wr);
            rd_ptr <= rd_ptr + PTR_W'(rd_cnt);
            count  <= count + CNT_W'(n_wr) - CNT_W'(rd_cnt);
            if (rd_cnt != '0) ds_pend <= br_last;
          end
          S_HOLD: begin
            wr_ptr <= wr_ptr + PTR_W'(n_wr);
            count  <= count + CNT_W'(n_wr);
            if (rd_cnt != '0) begin
              state   <= S_NORMAL;
              ds_pend <= 1'b0;
            end
          end
          S_WAIT: begin
            if (wr_cnt != '0) begin
              ds_reg <= wr_lane[0];
              state  <= S_HOLD;
            end
          end
          default: state <= S_NORMAL;
        endcase
      end
    end
  end

  wr_cnt_in_range: assert property (@(posedge clk)
    disable iff (!rst_n || flush || flush_keep_ds || state == S_WAIT)
    (CNT_W+1)'(wr_cnt) <= free);

endmodule

// File: tb/tb_instr_queue_mp.sv
// tb/tb_instr_queue_mp.sv - self-checking bench for instr_queue_mp
module tb_instr_queue_mp;

  localparam int DEPTH = 16;
  localparam int WRP   = 2;
  localparam int RDP   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        flush_keep_ds = 1'b0;
  logic [1:0]  wr_cnt = '0;
  logic [63:0] wr_data = '0;
  logic [63:0] wr_addr = '0;
  logic [23:0] wr_exp = '0;
  logic        wr_ready;
  logic [1:0]  rd_valid;
  logic [63:0] rd_data;
  logic [63:0] rd_addr;
  logic [23:0] rd_exp;
  logic [1:0]  rd_is_ds;
  logic [1:0]  rd_branch = '0;
  logic [1:0]  rd_cnt = '0;
  logic [4:0]  count;
  logic [63:0] perf_issued;

  always #5 clk = ~clk;

  instr_queue_mp dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .flush_keep_ds (flush_keep_ds),
    .wr_cnt        (wr_cnt),
    .wr_data       (wr_data),
    .wr_addr       (wr_addr),
    .wr_exp        (wr_exp),
    .wr_ready      (wr_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_addr       (rd_addr),
    .rd_exp        (rd_exp),
    .rd_is_ds      (rd_is_ds),
    .rd_branch     (rd_branch),
    .rd_cnt        (rd_cnt),
    .count         (count),
    .perf_issued   (perf_issued)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] a;
    logic [11:0] e;
  } ent_t;

  typedef struct {
    int f, k, wc, base, rc, br;
    int e_cnt, e_valid, e_ds0, e_addr0, e_ready;
  } vec_t;

  // Reference model: a plain FIFO plus a "pending delay slot" slot outside it.
  ent_t            mq[$];
  int              m_st;   // 0 normal, 1 holding a delay slot, 2 waiting for one
  ent_t            m_ds;
  logic            m_pend;
  longint unsigned m_perf;

  int checks   = 0;
  int failures = 0;
  vec_t tbl [31];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic ent_t mk_ent(input logic [31:0] base, input int i);
    ent_t r;
    r.a = base + 32'(4 * i);
    r.d = {r.a[15:0], ~r.a[15:0]};
    r.e = r.a[13:2] ^ 12'hA5A;
    return r;
  endfunction

  function automatic ent_t lane_ent(input int i);
    ent_t r;
    r.d = wr_data[i*32 +: 32];
    r.a = wr_addr[i*32 +: 32];
    r.e = wr_exp[i*12 +: 12];
    return r;
  endfunction

  function automatic vec_t mk_vec(input int f, k, wc, base, rc, br,
                                  input int e_cnt, e_valid, e_ds0, e_addr0, e_ready);
    vec_t v;
    v.f = f; v.k = k; v.wc = wc; v.base = base; v.rc = rc; v.br = br;
    v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_ds0 = e_ds0;
    v.e_addr0 = e_addr0; v.e_ready = e_ready;
    return v;
  endfunction

  task automatic drive(input int f, k, wc, base, rc, br);
    flush         = (f != 0);
    flush_keep_ds = (k != 0);
    wr_cnt        = 2'(wc);
    rd_cnt        = 2'(rc);
    rd_branch     = 2'(br);
    for (int i = 0; i < WRP; i++) begin
      ent_t e;
      e = mk_ent(32'(base), i);
      wr_data[i*32 +: 32] = e.d;
      wr_addr[i*32 +: 32] = e.a;
      wr_exp[i*12 +: 12]  = e.e;
    end
  endtask

  task automatic model_step();
    int wc;
    int rc;
    ent_t l0;
    wc = int'(wr_cnt);
    rc = int'(rd_cnt);
    l0 = lane_ent(0);
    if (flush) begin
      mq.delete();
      m_st   = 0;
      m_pend = 1'b0;
    end else if (flush_keep_ds) begin
      if (m_st == 0) begin
        m_perf += longint'(rc);
        for (int i = 0; i < rc; i++) void'(mq.pop_front());
        m_pend = 1'b0;
        if (mq.size() > 0) begin m_ds = mq[0]; m_st = 1; end
        else if (wc >= 1)  begin m_ds = l0;    m_st = 1; end
        else m_st = 2;
      end
      mq.delete();
    end else if (m_st == 0) begin
      for (int i = 0; i < rc; i++) void'(mq.pop_front());
      if (rc > 0) m_pend = rd_branch[rc-1];
      m_perf += longint'(rc);
      for (int i = 0; i < wc; i++) mq.push_back(lane_ent(i));
    end else if (m_st == 1) begin
      for (int i = 0; i < wc; i++) mq.push_back(lane_ent(i));
      if (rc >= 1) begin m_st = 0; m_pend = 1'b0; m_perf += 1; end
    end else begin
      if (wc >= 1) begin m_ds = l0; m_st = 1; end
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0]  ev;
    logic [1:0]  eds;
    logic [63:0] ed;
    logic [63:0] ea;
    logic [23:0] ee;
    ev = '0; eds = '0; ed = '0; ea = '0; ee = '0;
    if (m_st == 0) begin
      for (int i = 0; i < RDP; i++) begin
        if (i < mq.size()) begin
          ev[i] = 1'b1;
          ed[i*32 +: 32] = mq[i].d;
          ea[i*32 +: 32] = mq[i].a;
          ee[i*12 +: 12] = mq[i].e;
        end
      end
    end else if (m_st == 1) begin
      ev[0] = 1'b1;
      ed[31:0] = m_ds.d;
      ea[31:0] = m_ds.a;
      ee[11:0] = m_ds.e;
    end
    eds[0] = (m_st == 1) || (m_st == 0 && m_pend);
    eds[1] = rd_branch[0] && ev[1];
    chk({tag, ".valid"}, 64'(rd_valid), 64'(ev));
    chk({tag, ".is_ds"}, 64'(rd_is_ds), 64'(eds));
    chk({tag, ".data"},  rd_data, ed);
    chk({tag, ".addr"},  rd_addr, ea);
    chk({tag, ".exp"},   64'(rd_exp), 64'(ee));
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".wr_ready"}, 64'(wr_ready), 64'(DEPTH - mq.size() >= WRP));
    chk({tag, ".perf"},  perf_issued, m_perf);
  endtask

  task automatic step(input int f, k, wc, base, rc, br, input string tag);
    drive(f, k, wc, base, rc, br);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_st   = 0;
    m_pend = 1'b0;
    m_perf = 0;
  endtask

  initial begin
    model_reset();

    // Test 1: fill 2/cycle, then drain 2/cycle.
    for (int k = 0; k < 8; k++)
      tbl[k] = mk_vec(0, 0, 2, 'h100 + 8*k, 0, 0, 2*k + 2, 3, 0, 'h100, (k < 7) ? 1 : 0);
    for (int k = 1; k <= 8; k++)
      tbl[7+k] = mk_vec(0, 0, 0, 0, 2, 0, 16 - 2*k, (k < 8) ? 3 : 0, 0,
                        (k < 8) ? 'h100 + 8*k : 0, 1);
    // Test 3: redirect keeps the entry after a consumed branch as delay slot.
    tbl[16] = mk_vec(0, 0, 2, 'h100, 0, 0,   2, 3, 0, 'h100, 1);
    tbl[17] = mk_vec(0, 0, 2, 'h108, 0, 0,   4, 3, 0, 'h100, 1);
    tbl[18] = mk_vec(0, 1, 0, 0,     1, 1,   0, 1, 1, 'h104, 1);
    tbl[19] = mk_vec(0, 0, 0, 0,     1, 0,   0, 0, 0, 0,     1);
    // Test 4: delay slot not yet fetched.
    tbl[20] = mk_vec(0, 1, 0, 0,     0, 0,   0, 0, 0, 0,     1);
    tbl[21] = mk_vec(0, 0, 2, 'h200, 0, 0,   0, 1, 1, 'h200, 1);
    tbl[22] = mk_vec(0, 0, 0, 0,     1, 0,   0, 0, 0, 0,     1);
    // Test 5: flush wins over flush_keep_ds.
    tbl[23] = mk_vec(0, 0, 2, 'h300, 0, 0,   2, 3, 0, 'h300, 1);
    tbl[24] = mk_vec(0, 0, 2, 'h308, 0, 0,   4, 3, 0, 'h300, 1);
    tbl[25] = mk_vec(0, 0, 1, 'h310, 0, 0,   5, 3, 0, 'h300, 1);
    tbl[26] = mk_vec(1, 1, 2, 'h318, 2, 0,   0, 0, 0, 0,     1);
    // Test 6: branch on lane 1 tags next lane 0.
    tbl[27] = mk_vec(0, 0, 2, 'h400, 0, 0,   2, 3, 0, 'h400, 1);
    tbl[28] = mk_vec(0, 0, 2, 'h408, 0, 0,   4, 3, 0, 'h400, 1);
    tbl[29] = mk_vec(0, 0, 0, 0,     2, 2,   2, 3, 1, 'h408, 1);
    tbl[30] = mk_vec(0, 0, 0, 0,     2, 0,   0, 0, 0, 0,     1);

    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 31; v++) begin
      step(tbl[v].f, tbl[v].k, tbl[v].wc, tbl[v].base, tbl[v].rc, tbl[v].br, "tbl");
      chk($sformatf("v%0d.count", v), 64'(count), 64'(tbl[v].e_cnt));
      chk($sformatf("v%0d.valid", v), 64'(rd_valid), 64'(tbl[v].e_valid));
      chk($sformatf("v%0d.ds0", v), 64'(rd_is_ds[0]), 64'(tbl[v].e_ds0));
      chk($sformatf("v%0d.addr0", v), 64'(rd_addr[31:0]), 64'(tbl[v].e_addr0));
      chk($sformatf("v%0d.ready", v), 64'(wr_ready), 64'(tbl[v].e_ready));
    end
    chk("tbl.perf_total", perf_issued, 64'd23);

    // Test 2: full queue, simultaneous write and read across the wrap.
    for (int k = 0; k < 8; k++) step(0, 0, 2, 'h500 + 8*k, 0, 0, "fill");
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 2, 'h540 + 8*k, 2, 0, "full_rw");
      chk($sformatf("full_rw%0d.count", k), 64'(count), 64'd16);
    end

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int nvis, fr, wc, rc, f, k;
      nvis = (m_st == 0) ? ((mq.size() < RDP) ? mq.size() : RDP) : ((m_st == 1) ? 1 : 0);
      rc = int'($urandom_range(nvis, 0));
      fr = DEPTH - mq.size() + ((m_st == 0) ? rc : 0);
      wc = int'($urandom_range(2, 0));
      if (wc > fr) wc = fr;
      f = ($urandom_range(39, 0) == 0) ? 1 : 0;
      k = ($urandom_range(14, 0) == 0) ? 1 : 0;
      step(f, k, wc, int'($urandom & 32'hFFFF_FFFC), rc, int'($urandom_range(3, 0)), "rnd");
    end

    // Asynchronous reset mid-cycle with a non-empty queue.
    step(1, 0, 0, 0, 0, 0, "pre");
    step(0, 0, 2, 'h700, 0, 0, "pre");
    step(0, 0, 2, 'h708, 1, 1, "pre");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(rd_valid), 64'd0);
    chk("arst.is_ds", 64'(rd_is_ds), 64'd0);
    chk("arst.wr_ready", 64'(wr_ready), 64'd1);
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.perf", perf_issued, 64'd0);
    chk("arst.addr", rd_addr, 64'd0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 'h800, 0, 0, "post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
